axi_lite_write_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4-Lite write master between `NUM_REQ` requesters, each using the same simple ready/valid write interface (address + data) as the master's front end. It sits directly in front of the write master's `ready`/`valid`/`address`/`data` port and holds a grant across up to `MAX_BURST` back-to-back writes. It broadcasts the master's sticky `error` to all requesters and stops granting once that error is seen.

---
 rtl/axi_lite_write_arbiter.sv | 137 +++++++++++++
 tb/tb_axi_lite_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_write_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite write master between NUM_REQ ready/valid requesters.
// Latency: grant 1 cycle after a request seen in IDLE; writes then pass combinationally, one per cycle.
// Backpressure: owner's req_ready mirrors m_ready, non-owners never see ready; master error stops all grants.
module axi_lite_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          req_error,
  input  logic                          m_ready,
  output logic                          m_valid,
  output logic [ADDR_WIDTH-1:0]         m_address,
  output logic [ADDR_WIDTH-1:0]         m_data,
  input  logic                          m_error,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_ERROR} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  grant_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;

  // Per-requester views of the packed address/data buses
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[i] = req_data[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic owner_vld;
  logic hs;
  logic last_beat;

  assign owner_vld = req_valid[grant_id];
  assign hs        = (state == ST_GRANT) && owner_vld && m_ready;
  assign last_beat = (burst_cnt == CNT_W'(MAX_BURST - 1));

  // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit is the winner
  logic [NUM_REQ-1:0] req_rot;
  logic [ID_W-1:0]    pick_ofs;
  logic [ID_W:0]      pick_sum;
  logic [ID_W-1:0]    pick_id;

  assign req_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);

  // Priority scan of the rotated request vector
  always_comb begin
    pick_ofs = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_ofs = ID_W'(k);
    end
  end

  assign pick_sum = {1'b0, rr_ptr} + {1'b0, pick_ofs};
  assign pick_id  = (pick_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(pick_sum - (ID_W+1)'(NUM_REQ))
                                                      : pick_sum[ID_W-1:0];

  // State and arbitration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  // Next-state: error beats release, release rotates the pointer past the owner
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    cnt_nxt   = burst_cnt;
    case (state)
      ST_IDLE: begin
        if (m_error) begin
          state_nxt = ST_ERROR;
        end else if (|req_valid) begin
          state_nxt = ST_GRANT;
          grant_nxt = pick_id;
          cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (hs) cnt_nxt = burst_cnt + CNT_W'(1);
        if (m_error) begin
          state_nxt = ST_ERROR;
        end else if ((hs && last_beat) || !owner_vld) begin
          state_nxt = ST_IDLE;
          rr_nxt    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: only the owner sees m_ready; m_valid never depends on m_ready
  always_comb begin
    req_ready = '0;
    m_valid   = 1'b0;
    busy      = 1'b0;
    req_error = 1'b0;
    case (state)
      ST_GRANT: begin
        busy                = 1'b1;
        m_valid             = owner_vld;
        req_ready[grant_id] = m_ready;
      end
      ST_ERROR: req_error = 1'b1;
      default: ;
    endcase
  end

  assign m_address = addr_arr[grant_id];
  assign m_data    = data_arr[grant_id];

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Directed bench for axi_lite_write_arbiter with a handshake scoreboard.
// Stimulus drives requesters through a small stable-until-ready model; expected writes are queued.
// A negedge monitor pops one expected write per m_valid&m_ready and checks owner, payload and spacing.
module tb_axi_lite_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  gap;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_address;
  logic [N*AW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          req_error;
  logic          m_ready;
  logic          m_valid;
  logic [AW-1:0] m_address;
  logic [AW-1:0] m_data;
  logic          m_error;
  logic [1:0]    grant_id;
  logic          busy;

  axi_lite_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_address(req_address), .req_data(req_data),
    .req_ready(req_ready), .req_error(req_error),
    .m_ready(m_ready), .m_valid(m_valid), .m_address(m_address), .m_data(m_data),
    .m_error(m_error), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Requester model storage
  logic [31:0] wa [N][16];
  logic [31:0] wd [N][16];
  int          wcnt [N];
  int          whead [N];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_hs  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (whead[i] < wcnt[i]) begin
        req_valid[i]            = 1'b1;
        req_address[i*AW +: AW] = wa[i][whead[i]];
        req_data[i*AW +: AW]    = wd[i][whead[i]];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
    wa[i][wcnt[i]] = a;
    wd[i][wcnt[i]] = d;
    wcnt[i]++;
    drive();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      wcnt[i]  = 0;
      whead[i] = 0;
    end
    drive();
  endtask

  task automatic expect_wr(input int id, input logic [31:0] a, input logic [31:0] d, input int gap);
    exp_t e;
    e.id   = 2'(id);
    e.addr = a;
    e.data = d;
    e.gap  = 8'(gap);
    exp_q.push_back(e);
  endtask

  // Advance one cycle; returns at posedge+3 with new inputs applied and outputs settled
  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = reset ? '0 : (req_valid & req_ready);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) whead[i]++;
    drive();
    #2;
  endtask

  function automatic logic [31:0] ra(input int i, input int k);
    return 32'(32'h1000 * (i + 1) + 4 * k);
  endfunction

  function automatic logic [31:0] rd(input int i, input int k);
    return 32'(32'hD000_0000 + (i << 8) + k);
  endfunction

  // Monitor: every accepted write must match the next queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_handshake: got id %0d addr 0x%0h, required no handshake", grant_id, m_address);
        end else begin
          e = exp_q.pop_front();
          check("hs_grant_id", 32'(grant_id), 32'(e.id));
          check("hs_address", m_address, e.addr);
          check("hs_data", m_data, e.data);
          check("hs_req_ready", 32'(req_ready), 32'(4'b0001) << e.id);
          if (e.gap != 0) check("hs_gap", 32'(cyc - last_hs), 32'(e.gap));
        end
        last_hs = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required end of test");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; m_ready = 1'b0; m_error = 1'b0;
    req_valid = '0; req_address = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin
      wcnt[i] = 0;
      whead[i] = 0;
    end
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_req_error", 32'(req_error), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);

    // Single requester 2, three writes
    m_ready = 1'b1;
    load(2, 32'h10, 32'h1); load(2, 32'h14, 32'h2); load(2, 32'h18, 32'h3);
    expect_wr(2, 32'h10, 32'h1, 0); expect_wr(2, 32'h14, 32'h2, 1); expect_wr(2, 32'h18, 32'h3, 1);
    #1;
    check("single_idle_busy", 32'(busy), 0);
    check("single_idle_m_valid", 32'(m_valid), 0);
    step();
    check("single_busy", 32'(busy), 1);
    check("single_m_valid", 32'(m_valid), 1);
    check("single_grant_id", 32'(grant_id), 2);
    repeat (3) step();
    check("single_drop_busy", 32'(busy), 1);
    check("single_drop_m_valid", 32'(m_valid), 0);
    step();
    check("single_release_busy", 32'(busy), 0);
    repeat (2) step();

    // Wrap-around from rr_ptr=3: req 0 before req 2, valid-drop costs 2 bubbles
    load(0, 32'h100, 32'hA0); load(0, 32'h104, 32'hA1); load(2, 32'h200, 32'hB0);
    expect_wr(0, 32'h100, 32'hA0, 0); expect_wr(0, 32'h104, 32'hA1, 1); expect_wr(2, 32'h200, 32'hB0, 3);
    step();
    check("wrap_first_grant", 32'(grant_id), 0);
    repeat (6) step();
    check("wrap_done_busy", 32'(busy), 0);
    step();

    // Stall: req 1 held off by m_ready for 5 cycles
    m_ready = 1'b0;
    load(1, 32'h300, 32'hC0); load(1, 32'h304, 32'hC1);
    expect_wr(1, 32'h300, 32'hC0, 0); expect_wr(1, 32'h304, 32'hC1, 1);
    step();
    for (int j = 0; j < 5; j++) begin
      check("stall_address", m_address, 32'h300);
      check("stall_data", m_data, 32'hC0);
      check("stall_req_ready", 32'(req_ready), 0);
      check("stall_m_valid", 32'(m_valid), 1);
      check("stall_grant_id", 32'(grant_id), 1);
      step();
    end
    m_ready = 1'b1;
    #1;
    check("stall_release_ready", 32'(req_ready), 32'h2);
    repeat (4) step();

    // Reset in the middle of a burst from req 3 (rr_ptr=2)
    for (int k = 0; k < 4; k++) load(3, 32'(32'h600 + 4 * k), 32'(32'hF0 + k));
    expect_wr(3, 32'h600, 32'hF0, 0); expect_wr(3, 32'h604, 32'hF1, 1);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_m_valid", 32'(m_valid), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_req_error", 32'(req_error), 0);
    check("midrst_grant_id", 32'(grant_id), 0);

    // Round robin: all requesting, grants 0,1,2,3,0 with 4 writes each
    clear_reqs();
    for (int k = 0; k < 8; k++) load(0, ra(0, k), rd(0, k));
    for (int i = 1; i < N; i++) for (int k = 0; k < 4; k++) load(i, ra(i, k), rd(i, k));
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        expect_wr(b % 4, ra(b % 4, (b == 4) ? k + 4 : k), rd(b % 4, (b == 4) ? k + 4 : k),
                  (k != 0) ? 1 : ((b == 0) ? 0 : 2));
      end
    end
    step();
    check("rr_post_reset_grant", 32'(grant_id), 0);
    repeat (26) step();
    check("rr_done_busy", 32'(busy), 0);

    // Error mid-grant (rr_ptr=1): second handshake coincides with m_error
    for (int k = 0; k < 4; k++) load(1, 32'(32'h700 + 4 * k), 32'(32'h70 + k));
    load(3, 32'h800, 32'h80); load(3, 32'h804, 32'h81);
    expect_wr(1, 32'h700, 32'h70, 0); expect_wr(1, 32'h704, 32'h71, 1);
    step();
    step();
    m_error = 1'b1;
    step();
    check("err_req_error", 32'(req_error), 1);
    check("err_m_valid", 32'(m_valid), 0);
    check("err_req_ready", 32'(req_ready), 0);
    check("err_busy", 32'(busy), 0);
    m_error = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("err_sticky_req_error", 32'(req_error), 1);
      check("err_sticky_m_valid", 32'(m_valid), 0);
    end
    reset = 1'b1;
    clear_reqs();
    step();
    reset = 1'b0;
    check("post_err_req_error", 32'(req_error), 0);
    check("post_err_busy", 32'(busy), 0);
    // rr_ptr back at 0: req 0 served before req 3
    load(3, 32'h900, 32'h93); load(0, 32'hA00, 32'h90);
    expect_wr(0, 32'hA00, 32'h90, 0); expect_wr(3, 32'h900, 32'h93, 3);
    repeat (8) step();

    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
